tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Sequences the GEMM tile loop over the matrix/tile dimensions held in the control/status registers. It walks the tile offsets for m, n and k, and runs a load/compute handshake for each tile with the buffer loader and the systolic datapath. It also drives the ping-pong bank select and returns busy/done/err for the STATUS register. It sits between the CSR block and the datapath, replacing software-driven index writes.

## Interface
- DIM_W, 8: width of M/N/K/Tm/Tn/Tk.
- IDX_W, 16: width of element-offset outputs.

- clk  in  1  system clock. One clock domain; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse; begin a run (CTRL bit0).
- abort  in  1  one-cycle pulse; cancel a run (CTRL bit1).
- M, N, K  in  DIM_W each  matrix dimensions in elements.
- Tm, Tn, Tk  in  DIM_W each  tile sizes in elements.
- load_req  out  1  request to load the current tile into bank `bank_sel`.
- load_ack  in  1  loader has finished the current tile.
- compute_req  out  1  request to compute the current tile from bank `bank_sel`.
- compute_done  in  1  datapath has finished the current tile.
- m_idx, n_idx, k_idx  out  IDX_W each  element offset of the current tile.
- m_len, n_len, k_len  out  DIM_W each  valid extent of the current tile.
- last_k  out  1  current tile is the final k tile; the accumulator is written back.
- bank_sel  out  1  ping-pong bank for the current tile.
- busy  out  1  a run is in progress.
- done  out  1  run completed; sticky.
- err  out  1  bad config or abort; sticky.

## Operation
- States: IDLE, CHECK, LOAD, COMPUTE, NEXT, FINISH.
- IDLE
  - On start: latch M..Tk into internal registers (inputs are ignored after this), clear done and err, go to CHECK.
- CHECK
  - If any latched dimension is 0: set err, go to IDLE.
  - Otherwise clear all offsets to 0, clear bank_sel, go to LOAD.
- LOAD
  - load_req is high for as long as the state holds.
  - When load_ack is sampled high, go to COMPUTE.
- COMPUTE
  - compute_req is high for as long as the state holds.
  - When compute_done is sampled high, go to NEXT.
- NEXT
  - Advance offsets, k innermost, then n, then m.
  - If k_idx+Tk < K: k_idx += Tk.
  - Else k_idx = 0, and if n_idx+Tn < N: n_idx += Tn.
  - Else n_idx = 0, and if m_idx+Tm < M: m_idx += Tm.
  - Else go to FINISH.
  - On advance: toggle bank_sel, go to LOAD.
- FINISH: set done, go to IDLE.
- Tile extents are computed from the current offsets:
  - m_len = min(Tm, M−m_idx); same rule for n and k.
  - last_k = (k_idx+Tk >= K).
  - Compares use IDX_W+1-bit arithmetic, so nothing wraps.
- busy = 1 in every state except IDLE.
- status[2:0] = {err, done, busy}.
- start while busy is ignored.
- abort in any non-IDLE state: next state is IDLE, err is set, and both reqs drop the next cycle. abort in IDLE has no effect.
- abort and start in the same cycle: abort wins, and start is ignored.
- Reset mid-run: immediately IDLE with all outputs at their reset values. Outstanding acks are then ignored, because IDLE does not sample them.

## Timing
- Reset values:
  - state = IDLE.
  - all offsets, lens and reqs = 0.
  - last_k, bank_sel, busy, done, err = 0.
- All outputs are registered or decoded from registered state; no combinational path from input to output.
- Cycle latency:
  - start sampled at edge 0.
  - CHECK during cycle 1.
  - load_req high from cycle 2.
- Handshakes:
  - A req is held until its ack/done is sampled.
  - The req deasserts the cycle after the ack/done.
  - The ack may arrive in the first cycle the req is high.
  - An ack outside its matching state is ignored.
- Per tile with zero-wait acks: LOAD 1 + COMPUTE 1 + NEXT 1 = 3 cycles.
- Run with T tiles and zero-wait acks: busy is high for 1 + 3T + 1 cycles.
- done rises the cycle after FINISH and stays set until the next accepted start or reset.

## Test plan
- M=N=K=4, Tm=Tn=Tk=2, acks tied high:
  - 8 tiles; (m,n,k) offsets in order (0,0,0),(0,0,2),(0,2,0),(0,2,2),(2,0,0),(2,0,2),(2,2,0),(2,2,2).
  - last_k alternates 0,1; bank_sel toggles every tile.
  - done=1 and busy=0 after 26 cycles.
- M=5, N=1, K=3, Tm=2, Tn=1, Tk=2:
  - m_len sequence 2,2,1; k_len alternates 2,1; 6 tiles total.
- Tk=0, then start:
  - err=1 two cycles after start; load_req never asserts; status=3'b100.
- load_ack delayed 5 cycles:
  - load_req held 6 cycles, then compute_req asserts; an early compute_done during LOAD is ignored.
- abort in COMPUTE of tile 3:
  - compute_req drops next cycle; busy=0, err=1, done=0.
  - A following start runs cleanly from offset (0,0,0).
- start pulsed mid-run:
  - no effect on indices.
- rst_n low mid-LOAD:
  - all outputs 0 asynchronously.

Source files
------------

// File: rtl/tile_scheduler_if.sv
// rtl/tile_scheduler_if.sv - CSR config, loader/datapath handshake and status bundle of the tile scheduler
interface tile_scheduler_if #(
    parameter int DIM_W = 8,
    parameter int IDX_W = 16
);
    logic             start;
    logic             abort;
    logic [DIM_W-1:0] M, N, K;
    logic [DIM_W-1:0] Tm, Tn, Tk;
    logic             load_req;
    logic             load_ack;
    logic             compute_req;
    logic             compute_done;
    logic [IDX_W-1:0] m_idx, n_idx, k_idx;
    logic [DIM_W-1:0] m_len, n_len, k_len;
    logic             last_k;
    logic             bank_sel;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, abort, M, N, K, Tm, Tn, Tk, load_ack, compute_done,
        output load_req, compute_req, m_idx, n_idx, k_idx, m_len, n_len, k_len,
               last_k, bank_sel, busy, done, err
    );

    modport slave (
        output start, abort, M, N, K, Tm, Tn, Tk, load_ack, compute_done,
        input  load_req, compute_req, m_idx, n_idx, k_idx, m_len, n_len, k_len,
               last_k, bank_sel, busy, done, err
    );
endinterface

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - GEMM tile-loop sequencer driving load/compute handshakes and ping-pong bank select
module tile_scheduler #(
    parameter int DIM_W = 8,
    parameter int IDX_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tile_scheduler_if.master  sched_if
);
    typedef enum logic [2:0] {IDLE, CHECK, LOAD, COMPUTE, NEXT, FINISH} state_t;
    typedef logic [IDX_W:0] wide_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] m_dim_q, m_dim_d, n_dim_q, n_dim_d, k_dim_q, k_dim_d;
    logic [DIM_W-1:0] tm_q, tm_d, tn_q, tn_d, tk_q, tk_d;
    logic [IDX_W-1:0] m_idx_q, m_idx_d, n_idx_q, n_idx_d, k_idx_q, k_idx_d;
    logic             bank_q, bank_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // One extra bit keeps offset+tile and dim-offset from wrapping.
    wide_t m_sum, n_sum, k_sum;
    wide_t m_rem, n_rem, k_rem;

    always_comb begin
        m_sum = wide_t'(m_idx_q) + wide_t'(tm_q);
        n_sum = wide_t'(n_idx_q) + wide_t'(tn_q);
        k_sum = wide_t'(k_idx_q) + wide_t'(tk_q);
        m_rem = wide_t'(m_dim_q) - wide_t'(m_idx_q);
        n_rem = wide_t'(n_dim_q) - wide_t'(n_idx_q);
        k_rem = wide_t'(k_dim_q) - wide_t'(k_idx_q);
    end

    always_comb begin
        state_d = state_q;
        m_dim_d = m_dim_q;
        n_dim_d = n_dim_q;
        k_dim_d = k_dim_q;
        tm_d    = tm_q;
        tn_d    = tn_q;
        tk_d    = tk_q;
        m_idx_d = m_idx_q;
        n_idx_d = n_idx_q;
        k_idx_d = k_idx_q;
        bank_d  = bank_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (sched_if.start && !sched_if.abort) begin
                    m_dim_d = sched_if.M;
                    n_dim_d = sched_if.N;
                    k_dim_d = sched_if.K;
                    tm_d    = sched_if.Tm;
                    tn_d    = sched_if.Tn;
                    tk_d    = sched_if.Tk;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (m_dim_q == '0 || n_dim_q == '0 || k_dim_q == '0 ||
                    tm_q == '0 || tn_q == '0 || tk_q == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    m_idx_d = '0;
                    n_idx_d = '0;
                    k_idx_d = '0;
                    bank_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sched_if.load_ack) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (sched_if.compute_done) state_d = NEXT;
            end
            NEXT: begin
                // k innermost, then n, then m; bank flips on every advance.
                bank_d  = ~bank_q;
                state_d = LOAD;
                if (k_sum < wide_t'(k_dim_q)) begin
                    k_idx_d = k_sum[IDX_W-1:0];
                end else begin
                    k_idx_d = '0;
                    if (n_sum < wide_t'(n_dim_q)) begin
                        n_idx_d = n_sum[IDX_W-1:0];
                    end else begin
                        n_idx_d = '0;
                        if (m_sum < wide_t'(m_dim_q)) begin
                            m_idx_d = m_sum[IDX_W-1:0];
                        end else begin
                            bank_d  = bank_q;
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (sched_if.abort && state_q != IDLE) begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_dim_q <= '0;
            n_dim_q <= '0;
            k_dim_q <= '0;
            tm_q    <= '0;
            tn_q    <= '0;
            tk_q    <= '0;
            m_idx_q <= '0;
            n_idx_q <= '0;
            k_idx_q <= '0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_dim_q <= m_dim_d;
            n_dim_q <= n_dim_d;
            k_dim_q <= k_dim_d;
            tm_q    <= tm_d;
            tn_q    <= tn_d;
            tk_q    <= tk_d;
            m_idx_q <= m_idx_d;
            n_idx_q <= n_idx_d;
            k_idx_q <= k_idx_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sched_if.load_req    = (state_q == LOAD);
    assign sched_if.compute_req = (state_q == COMPUTE);
    assign sched_if.busy        = (state_q != IDLE);
    assign sched_if.done        = done_q;
    assign sched_if.err         = err_q;
    assign sched_if.bank_sel    = bank_q;
    assign sched_if.m_idx       = m_idx_q;
    assign sched_if.n_idx       = n_idx_q;
    assign sched_if.k_idx       = k_idx_q;
    assign sched_if.m_len       = (wide_t'(tm_q) < m_rem) ? tm_q : m_rem[DIM_W-1:0];
    assign sched_if.n_len       = (wide_t'(tn_q) < n_rem) ? tn_q : n_rem[DIM_W-1:0];
    assign sched_if.k_len       = (wide_t'(tk_q) < k_rem) ? tk_q : k_rem[DIM_W-1:0];
    // Zero K (reset or unconfigured) must not report a final k tile.
    assign sched_if.last_k      = (k_dim_q != '0) && (k_sum >= wide_t'(k_dim_q));
endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - directed self-checking bench for tile_scheduler
module tb_tile_scheduler;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tile_scheduler_if #(.DIM_W(8), .IDX_W(16)) sif ();

    tile_scheduler #(.DIM_W(8), .IDX_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] m_idx;
        logic [15:0] n_idx;
        logic [15:0] k_idx;
        logic [7:0]  m_len;
        logic [7:0]  n_len;
        logic [7:0]  k_len;
        logic        last_k;
        logic        bank_sel;
    } tile_t;

    tile_t tiles[$];

    int exp1_m [8] = '{0, 0, 0, 0, 2, 2, 2, 2};
    int exp1_n [8] = '{0, 0, 2, 2, 0, 0, 2, 2};
    int exp1_k [8] = '{0, 2, 0, 2, 0, 2, 0, 2};
    int exp2_m [6] = '{0, 0, 2, 2, 4, 4};
    int exp2_ml[6] = '{2, 2, 2, 2, 1, 1};
    int exp2_k [6] = '{0, 2, 0, 2, 0, 2};
    int exp2_kl[6] = '{2, 1, 2, 1, 2, 1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int m, input int n, input int k,
                           input int tm, input int tn, input int tk);
        sif.M  = 8'(m);
        sif.N  = 8'(n);
        sif.K  = 8'(k);
        sif.Tm = 8'(tm);
        sif.Tn = 8'(tn);
        sif.Tk = 8'(tk);
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    // Starts a run and records each tile on the first cycle of its LOAD.
    task automatic run_collect(input int max_cycles, input int start_pulse_at,
                               output int busy_cycles);
        logic  prev_load;
        tile_t t;
        tiles.delete();
        busy_cycles = 0;
        prev_load   = 1'b0;
        pulse_start();
        for (int c = 0; c < max_cycles; c++) begin
            if (!sif.busy) break;
            busy_cycles++;
            if (sif.load_req && !prev_load) begin
                t.m_idx    = sif.m_idx;
                t.n_idx    = sif.n_idx;
                t.k_idx    = sif.k_idx;
                t.m_len    = sif.m_len;
                t.n_len    = sif.n_len;
                t.k_len    = sif.k_len;
                t.last_k   = sif.last_k;
                t.bank_sel = sif.bank_sel;
                tiles.push_back(t);
            end
            prev_load = sif.load_req;
            sif.start = (c == start_pulse_at);
            @(negedge clk);
        end
        sif.start = 1'b0;
        check_eq("run_timeout", 64'(sif.busy), 64'd0);
    endtask

    task automatic wait_compute(input string tag);
        for (int c = 0; c < 20; c++) begin
            if (sif.compute_req) break;
            @(negedge clk);
        end
        check_eq(tag, 64'(sif.compute_req), 64'd1);
    endtask

    task automatic check_t1_tiles(input string pfx);
        check_eq({pfx, "_ntiles"}, 64'(tiles.size()), 64'd8);
        for (int i = 0; i < tiles.size() && i < 8; i++) begin
            check_eq($sformatf("%s_tile%0d", pfx, i),
                     {8'd0, tiles[i].m_idx, tiles[i].n_idx, tiles[i].k_idx,
                      6'd0, tiles[i].last_k, tiles[i].bank_sel},
                     {8'd0, 16'(exp1_m[i]), 16'(exp1_n[i]), 16'(exp1_k[i]),
                      6'd0, 1'(i % 2), 1'(i % 2)});
            check_eq($sformatf("%s_len%0d", pfx, i),
                     64'({tiles[i].m_len, tiles[i].n_len, tiles[i].k_len}), 64'h020202);
        end
    endtask

    initial begin
        int   bc;
        logic saw_load;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.load_ack = 1'b0;
        sif.compute_done = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_idx", {16'd0, sif.m_idx, sif.n_idx, sif.k_idx}, 64'd0);
        check_eq("reset_ctl", 64'({sif.m_len, sif.n_len, sif.k_len, sif.load_req, sif.compute_req,
                                   sif.last_k, sif.bank_sel, sif.busy, sif.done, sif.err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort alone in IDLE, then abort together with start
        set_cfg(4, 4, 4, 2, 2, 2);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check_eq("idle_abort", 64'({sif.busy, sif.err}), 64'd0);
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        check_eq("start_abort_same", 64'({sif.busy, sif.err}), 64'd0);
        @(negedge clk);
        check_eq("start_abort_after", 64'(sif.busy), 64'd0);

        // 4x4x4 in 2x2x2 tiles, acks tied high
        sif.load_ack = 1'b1;
        sif.compute_done = 1'b1;
        run_collect(100, -1, bc);
        check_eq("t1_busy_cycles", 64'(bc), 64'd26);
        check_eq("t1_status", 64'({sif.err, sif.done, sif.busy}), 64'b010);
        check_t1_tiles("t1");

        // ragged edges: M=5,N=1,K=3 with Tm=2,Tn=1,Tk=2
        set_cfg(5, 1, 3, 2, 1, 2);
        run_collect(100, -1, bc);
        check_eq("t2_busy_cycles", 64'(bc), 64'd20);
        check_eq("t2_ntiles", 64'(tiles.size()), 64'd6);
        for (int i = 0; i < tiles.size() && i < 6; i++) begin
            check_eq($sformatf("t2_tile%0d", i),
                     {tiles[i].m_idx, tiles[i].k_idx, tiles[i].m_len, tiles[i].n_len,
                      tiles[i].k_len, 6'd0, tiles[i].last_k, tiles[i].bank_sel},
                     {16'(exp2_m[i]), 16'(exp2_k[i]), 8'(exp2_ml[i]), 8'd1,
                      8'(exp2_kl[i]), 6'd0, 1'(i % 2), 1'(i % 2)});
        end

        // zero tile size
        set_cfg(4, 4, 4, 2, 2, 0);
        pulse_start();
        check_eq("t3_check_cycle", 64'({sif.err, sif.busy, sif.load_req}), 64'b010);
        saw_load = 1'b0;
        @(negedge clk);
        check_eq("t3_status", 64'({sif.err, sif.done, sif.busy}), 64'b100);
        for (int c = 0; c < 4; c++) begin
            saw_load |= sif.load_req;
            @(negedge clk);
        end
        check_eq("t3_no_load", 64'(saw_load), 64'd0);

        // load_ack delayed 5 cycles with an early compute_done during LOAD
        set_cfg(1, 1, 1, 1, 1, 1);
        sif.load_ack = 1'b0;
        sif.compute_done = 1'b1;
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t4_hold%0d", i), 64'({sif.load_req, sif.compute_req}), 64'b10);
            if (i == 5) sif.load_ack = 1'b1;
            @(negedge clk);
        end
        check_eq("t4_compute", 64'({sif.load_req, sif.compute_req}), 64'b01);
        sif.load_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!sif.busy) break;
            @(negedge clk);
        end
        check_eq("t4_done", 64'({sif.err, sif.done, sif.busy}), 64'b010);

        // abort in COMPUTE of the third tile
        set_cfg(4, 4, 4, 2, 2, 2);
        sif.load_ack = 1'b1;
        sif.compute_done = 1'b0;
        pulse_start();
        for (int t = 0; t < 2; t++) begin
            wait_compute($sformatf("t5_compute%0d", t));
            sif.compute_done = 1'b1;
            @(negedge clk);
            sif.compute_done = 1'b0;
        end
        wait_compute("t5_compute2");
        check_eq("t5_tile3_idx", {16'd0, sif.m_idx, sif.n_idx, sif.k_idx}, {16'd0, 16'd0, 16'd2, 16'd0});
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check_eq("t5_abort", 64'({sif.compute_req, sif.busy, sif.err, sif.done}), 64'b0010);

        // clean rerun with a start pulsed mid-run
        sif.compute_done = 1'b1;
        run_collect(100, 10, bc);
        check_eq("t6_busy_cycles", 64'(bc), 64'd26);
        check_eq("t6_status", 64'({sif.err, sif.done, sif.busy}), 64'b010);
        check_t1_tiles("t6");

        // asynchronous reset while in LOAD
        sif.load_ack = 1'b0;
        sif.compute_done = 1'b0;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            if (sif.load_req) break;
            @(negedge clk);
        end
        check_eq("t7_in_load", 64'(sif.load_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_rst_idx", {16'd0, sif.m_idx, sif.n_idx, sif.k_idx}, 64'd0);
        check_eq("t7_rst_ctl", 64'({sif.m_len, sif.n_len, sif.k_len, sif.load_req, sif.compute_req,
                                    sif.last_k, sif.bank_sel, sif.busy, sif.done, sif.err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sif.load_ack = 1'b1;
        sif.compute_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t7_acks_ignored", 64'({sif.busy, sif.load_req, sif.compute_req}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
